uni_shift_rx: RTL and testbench

Serial-to-parallel receiver: the receive-side counterpart to the team's universal shift register, which serialises a parallel word by shifting it left or right. This block accepts a bit-strobed serial stream in either bit order and assembles WIDTH-bit words. It presents each word on a registered valid/ready output port, reports overrun, and can optionally check parity. It sits between a serial link and any parallel consumer in the datapath.

---
 rtl/uni_shift_rx_pkg.sv | 20 ++
 rtl/uni_shift_rx_if.sv | 15 +
 rtl/uni_shift_rx_core.sv | 59 +++++
 rtl/uni_shift_rx.sv | 154 +++++++++++++++
 tb/tb_uni_shift_rx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uni_shift_rx_pkg.sv
// uni_shift_pkg: shared types and constants for the uni_shift_rx receiver.
//   state_t        FSM states (PAR only when UNI_SHIFT_RX_PARITY_EN is defined)
//   DIR_*          bit-order encodings for the dir input
//   cnt_width()    bit-counter width for a given WIDTH (must hold 0..WIDTH)
package uni_shift_pkg;

`ifdef UNI_SHIFT_RX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/uni_shift_rx_if.sv
// uni_shift_rx_if: parallel word output port of uni_shift_rx.
//   out_data   received word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts the word on an edge with out_valid & out_ready
// master = receiver side, slave = consumer side.
interface uni_shift_rx_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uni_shift_rx_core.sv
// rx_shift_core: bidirectional shift register with bit counter.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        restart: word and count start from zero this cycle
//   i_shift_en   shift i_sin in and bump the count
//   i_dir        1 = shift left (bit enters at 0), 0 = shift right (bit enters at WIDTH-1)
//   i_sin        serial bit
//   o_word       word including the bit being shifted this cycle
//   o_count      registered count of bits shifted so far
module rx_shift_core
   import uni_shift_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CW    = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_shift_en,
   input  logic             i_dir,
   input  logic             i_sin,
   output logic [WIDTH-1:0] o_word,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_word;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_shifted;
   logic [CW-1:0]    w_cnt_base;

   always_comb begin
      w_base     = i_clr ? '0 : r_word;
      w_cnt_base = i_clr ? '0 : r_count;
      if (i_dir == DIR_MSB_FIRST) begin
         w_shifted = {w_base[WIDTH-2:0], i_sin};
      end else begin
         w_shifted = {i_sin, w_base[WIDTH-1:1]};
      end
   end

   // Exposing the post-shift value lets the top deliver a word on the
   // same edge that samples its last bit.
   assign o_word  = i_shift_en ? w_shifted : w_base;
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word  <= '0;
         r_count <= '0;
      end else if (i_shift_en) begin
         r_word  <= w_shifted;
         r_count <= w_cnt_base + 1'b1;
      end else if (i_clr) begin
         r_word  <= '0;
         r_count <= '0;
      end
   end

endmodule

// File: rtl/uni_shift_rx.sv
// uni_shift_rx: serial-to-parallel receiver, either bit order.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      frame-start pulse (restarts any frame in progress)
//   dir        bit order sampled with start (1 = MSB first, 0 = LSB first)
//   sin        serial bit, sampled when sin_valid = 1
//   sin_valid  serial bit strobe
//   out_if     word output port (uni_shift_rx_if master)
//   busy       frame in progress
//   overrun    sticky: completed word dropped because the output was full
//   err_clr    clears overrun/perr on the next edge (a new error wins)
//   perr       sticky parity error (only with UNI_SHIFT_RX_PARITY_EN)
// Build option: UNI_SHIFT_RX_PARITY_EN adds one trailing even-parity bit.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | collecting data bits
// PAR   | waiting for the parity bit (parity builds only)
module uni_shift_rx
   import uni_shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  dir,
   input  logic                  sin,
   input  logic                  sin_valid,
   uni_shift_rx_if.master        out_if,
   output logic                  busy,
   output logic                  overrun,
`ifdef UNI_SHIFT_RX_PARITY_EN
   output logic                  perr,
`endif
   input  logic                  err_clr
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           r_state;
   logic             r_dir;
   logic             r_busy;
   logic             r_overrun;
   logic             w_dir;
   logic             w_shift_en;
   logic             w_last_bit;
   logic             w_deliver;
   logic             w_full;
   logic             w_accept;
   logic [WIDTH-1:0] w_word;
   logic [CW-1:0]    w_count;

   assign w_dir      = start ? dir : r_dir;
   assign w_shift_en = sin_valid & (start | (r_state == SHIFT));
   // A start cycle can never complete a frame since WIDTH >= 2.
   assign w_last_bit = !start && (r_state == SHIFT) && sin_valid && (w_count == LAST_CNT);
   assign w_full     = out_if.out_valid & ~out_if.out_ready;
   assign w_accept   = out_if.out_valid & out_if.out_ready;

`ifdef UNI_SHIFT_RX_PARITY_EN
   logic r_perr;
   logic w_par_bit;
   logic w_par_fail;
   assign w_par_bit  = !start && (r_state == PAR) && sin_valid;
   assign w_par_fail = w_par_bit & ((^w_word) ^ sin);
   assign w_deliver  = w_par_bit & ~w_par_fail;
   assign perr       = r_perr;
`else
   assign w_deliver  = w_last_bit;
`endif

   rx_shift_core #(.WIDTH(WIDTH), .CW(CW)) u_core (
      .clk        (clk),
      .rst_n      (reset),
      .i_clr      (start),
      .i_shift_en (w_shift_en),
      .i_dir      (w_dir),
      .i_sin      (sin),
      .o_word     (w_word),
      .o_count    (w_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= IDLE;
         r_dir            <= DIR_LSB_FIRST;
         r_busy           <= 1'b0;
         r_overrun        <= 1'b0;
         out_if.out_data  <= '0;
         out_if.out_valid <= 1'b0;
`ifdef UNI_SHIFT_RX_PARITY_EN
         r_perr           <= 1'b0;
`endif
      end else begin
         if (start) begin
            r_state <= SHIFT;
            r_dir   <= dir;
            r_busy  <= 1'b1;
         end else begin
            case (r_state)
               SHIFT: begin
                  if (w_last_bit) begin
`ifdef UNI_SHIFT_RX_PARITY_EN
                     r_state <= PAR;
`else
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
`endif
                  end
               end
`ifdef UNI_SHIFT_RX_PARITY_EN
               PAR: begin
                  if (sin_valid) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
`endif
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end

         if (w_deliver && !w_full) begin
            out_if.out_data  <= w_word;
            out_if.out_valid <= 1'b1;
         end else if (w_accept) begin
            out_if.out_valid <= 1'b0;
         end

         if (w_deliver && w_full) begin
            r_overrun <= 1'b1;
         end else if (err_clr) begin
            r_overrun <= 1'b0;
         end

`ifdef UNI_SHIFT_RX_PARITY_EN
         if (w_par_fail) begin
            r_perr <= 1'b1;
         end else if (err_clr) begin
            r_perr <= 1'b0;
         end
`endif
      end
   end

   assign busy    = r_busy;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_uni_shift_rx.sv
module tb_uni_shift_rx;
   import uni_shift_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic dir = 1'b0;
   logic sin = 1'b0;
   logic sin_valid = 1'b0;
   logic err_clr = 1'b0;
   logic busy;
   logic overrun;
`ifdef UNI_SHIFT_RX_PARITY_EN
   logic perr;
`endif

   uni_shift_rx_if #(.WIDTH(W)) u_if ();

   uni_shift_rx #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .start     (start),
      .dir       (dir),
      .sin       (sin),
      .sin_valid (sin_valid),
      .out_if    (u_if),
      .busy      (busy),
      .overrun   (overrun),
`ifdef UNI_SHIFT_RX_PARITY_EN
      .perr      (perr),
`endif
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_q[$];
   logic exp_overrun = 1'b0;
   logic exp_perr = 1'b0;
   logic prev_hold = 1'b0;
   logic [W-1:0] prev_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: i-th transmitted bit lands at position WIDTH-1-i when
   // MSB-first, at position i when LSB-first.
   function automatic logic [W-1:0] assemble(input logic d, input logic [W-1:0] seq);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         if (d == DIR_MSB_FIRST) r[W-1-i] = seq[i];
         else                    r[i]     = seq[i];
      end
      return r;
   endfunction

   // seq[i] is the i-th bit put on the wire
   function automatic logic [W-1:0] seq4(input logic b0, input logic b1, input logic b2, input logic b3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic cyc(input logic st, input logic d, input logic s, input logic sv, input logic ec);
      start = st; dir = d; sin = s; sin_valid = sv; err_clr = ec;
      @(posedge clk);
      #1;
      start = 1'b0; sin_valid = 1'b0; err_clr = 1'b0; sin = 1'($urandom);
   endtask

   task automatic gaps(input int max_gap);
      repeat ($urandom_range(0, max_gap)) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
   endtask

   // Model of a completed, parity-clean word reaching the output port.
   task automatic model_word(input logic [W-1:0] w, input logic clr);
      if (u_if.out_ready == 1'b0 && exp_q.size() > 0) begin
         exp_overrun = 1'b1;
      end else begin
         exp_q.push_back(w);
         if (clr) begin
            exp_overrun = 1'b0;
            exp_perr = 1'b0;
         end
      end
   endtask

   task automatic send(input logic d, input logic [W-1:0] seq, input int max_gap, input logic clr_last);
      logic [W-1:0] w;
      int k;
      w = assemble(d, seq);
      k = 0;
      if ($urandom_range(0, 1) == 1) begin
         cyc(1'b1, d, seq[0], 1'b1, 1'b0);
         k = 1;
      end else begin
         cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
      end
      check("busy_in_frame", {31'd0, busy}, 32'd1);
`ifdef UNI_SHIFT_RX_PARITY_EN
      for (int i = k; i < W; i++) begin
         gaps(max_gap);
         cyc(1'b0, 1'($urandom), seq[i], 1'b1, 1'b0);
      end
      gaps(max_gap);
      cyc(1'b0, 1'($urandom), ^w, 1'b1, clr_last);
`else
      for (int i = k; i < W; i++) begin
         gaps(max_gap);
         cyc(1'b0, 1'($urandom), seq[i], 1'b1, clr_last && (i == W - 1));
      end
`endif
      model_word(w, clr_last);
      check("busy_after_frame", {31'd0, busy}, 32'd0);
   endtask

`ifdef UNI_SHIFT_RX_PARITY_EN
   task automatic send_par(input logic d, input logic [W-1:0] seq, input logic pbit);
      logic [W-1:0] w;
      w = assemble(d, seq);
      cyc(1'b1, d, seq[0], 1'b1, 1'b0);
      for (int i = 1; i < W; i++) cyc(1'b0, 1'($urandom), seq[i], 1'b1, 1'b0);
      cyc(1'b0, 1'($urandom), pbit, 1'b1, 1'b0);
      if (((^w) ^ pbit) == 1'b0) model_word(w, 1'b0);
      else exp_perr = 1'b1;
   endtask
`endif

   // Monitor: pops the scoreboard on every accepting edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && u_if.out_valid) begin
            if (prev_hold) check("hold_stable", {28'd0, u_if.out_data}, {28'd0, prev_data});
            if (u_if.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_word: got %0h, expected no word (t=%0t)", u_if.out_data, $time);
               end else begin
                  check("word", {28'd0, u_if.out_data}, {28'd0, exp_q.pop_front()});
               end
            end
         end
         prev_hold = rst_n && u_if.out_valid && !u_if.out_ready;
         prev_data = u_if.out_data;
      end
   end

   initial begin
      int guard;
      u_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, u_if.out_valid}, 32'd0);
      check("rst_data", {28'd0, u_if.out_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(DIR_MSB_FIRST, seq4(1, 0, 1, 1), 0, 1'b0);
      send(DIR_LSB_FIRST, seq4(1, 0, 1, 1), 0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Backpressure and overrun
      u_if.out_ready = 1'b0;
      send(DIR_MSB_FIRST, seq4(0, 0, 1, 1), 0, 1'b0);
      send(DIR_MSB_FIRST, seq4(0, 1, 0, 1), 0, 1'b0);
      check("bp_data", {28'd0, u_if.out_data}, 32'h3);
      check("bp_valid", {31'd0, u_if.out_valid}, 32'd1);
      check("bp_overrun", {31'd0, overrun}, {31'd0, exp_overrun});
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_overrun = 1'b0;
      check("overrun_cleared", {31'd0, overrun}, 32'd0);
      // New drop together with err_clr: the drop wins
      send(DIR_LSB_FIRST, seq4(1, 1, 1, 0), 0, 1'b1);
      check("clr_vs_err", {31'd0, overrun}, {31'd0, exp_overrun});
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_overrun = 1'b0;
      u_if.out_ready = 1'b1;
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Restart mid-frame, then with random stalls
      for (int g = 0; g < 2; g++) begin
         cyc(1'b1, DIR_LSB_FIRST, 1'b1, 1'b1, 1'b0);
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         send(DIR_MSB_FIRST, seq4(0, 1, 1, 0), (g == 0) ? 0 : 3, 1'b0);
         check("restart_overrun", {31'd0, overrun}, {31'd0, exp_overrun});
      end

      // Asynchronous reset mid-frame
      cyc(1'b1, DIR_MSB_FIRST, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_data", {28'd0, u_if.out_data}, 32'd0);
      check("mid_rst_valid", {31'd0, u_if.out_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(DIR_MSB_FIRST, seq4(1, 0, 0, 1), 0, 1'b0);

`ifdef UNI_SHIFT_RX_PARITY_EN
      send_par(DIR_MSB_FIRST, seq4(1, 0, 1, 1), 1'b1);
      check("par_ok_perr", {31'd0, perr}, {31'd0, exp_perr});
      send_par(DIR_MSB_FIRST, seq4(1, 0, 1, 1), 1'b0);
      check("par_bad_perr", {31'd0, perr}, {31'd0, exp_perr});
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_perr = 1'b0;
      check("perr_cleared", {31'd0, perr}, 32'd0);
`endif

      // Randomized back-to-back frames
      for (int n = 0; n < 30; n++) begin
         send(1'($urandom), W'($urandom), 2, 1'b0);
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d words outstanding, expected 0", exp_q.size());
      end
      check("final_overrun", {31'd0, overrun}, {31'd0, exp_overrun});
      check("final_valid", {31'd0, u_if.out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
